// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, issue FSM states and flag-selection helpers for the ALU front-end
package alu_pkg;
    localparam logic [3:0] OP_LOAD      = 4'd0;
    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_ADD_CARRY = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_INC       = 4'd4;
    localparam logic [3:0] OP_DEC       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_NOT       = 4'd7;
    localparam logic [3:0] OP_ROL       = 4'd8;
    localparam logic [3:0] OP_ROR       = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    function automatic logic uses_carry(input logic [3:0] op);
        return op == OP_ADD || op == OP_ADD_CARRY || op == OP_INC;
    endfunction

    function automatic logic uses_borrow(input logic [3:0] op);
        return op == OP_SUB || op == OP_DEC;
    endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: register file with two captured read ports, one write port and a combinational debug port
module alu_regfile #(
    parameter  int BUS_WIDTH = 8,
    parameter  int NUM_REGS  = 4,
    localparam int REG_AW    = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rd_en,
    input  logic [REG_AW-1:0]    i_ra,
    input  logic [REG_AW-1:0]    i_rb,
    output logic [BUS_WIDTH-1:0] o_rd_a,
    output logic [BUS_WIDTH-1:0] o_rd_b,
    input  logic                 i_we,
    input  logic [REG_AW-1:0]    i_wa,
    input  logic [BUS_WIDTH-1:0] i_wd,
    input  logic [REG_AW-1:0]    i_dbg_addr,
    output logic [BUS_WIDTH-1:0] o_dbg_data
);
    logic [BUS_WIDTH-1:0] r_mem [NUM_REGS];

    // Storage clear, write-back, and operand capture held until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
            o_rd_a <= '0;
            o_rd_b <= '0;
        end else begin
            if (i_we) r_mem[i_wa] <= i_wd;
            if (i_rd_en) begin
                o_rd_a <= r_mem[i_ra];
                o_rd_b <= r_mem[i_rb];
            end
        end
    end

    assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: three-cycle issue/execute/write-back sequencer in front of the combinational ALU
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter  int BUS_WIDTH = 8,
    parameter  int NUM_REGS  = 4,
    localparam int REG_AW    = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr_op,
    input  logic [REG_AW-1:0]    instr_rd,
    input  logic [REG_AW-1:0]    instr_ra,
    input  logic [REG_AW-1:0]    instr_rb,
    input  logic [BUS_WIDTH-1:0] instr_imm,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_carry_in,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_carry_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic                 done_valid,
    output logic [BUS_WIDTH-1:0] done_result,
    output logic                 done_err,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_p,
    output logic                 err_sticky,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [BUS_WIDTH-1:0] dbg_data
);
    state_t               r_state;
    logic [3:0]           r_op;
    logic [REG_AW-1:0]    r_rd;
    logic [BUS_WIDTH-1:0] r_imm;
    logic [BUS_WIDTH-1:0] r_y;
    logic                 r_co;
    logic                 r_bo;
    logic                 r_z;
    logic                 r_p;
    logic                 r_inv;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_we;
    logic [BUS_WIDTH-1:0] w_wdata;

    assign instr_ready = r_state == S_IDLE;
    assign w_accept    = instr_ready && instr_valid;
    assign w_load      = r_op == OP_LOAD;
    assign w_we        = r_state == S_WB && (w_load || !r_inv);
    assign w_wdata     = w_load ? r_imm : r_y;

    alu_regfile #(
        .BUS_WIDTH(BUS_WIDTH),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_rd_en   (w_accept),
        .i_ra      (instr_ra),
        .i_rb      (instr_rb),
        .o_rd_a    (alu_a),
        .o_rd_b    (alu_b),
        .i_we      (w_we),
        .i_wa      (r_rd),
        .i_wd      (w_wdata),
        .i_dbg_addr(dbg_addr),
        .o_dbg_data(dbg_data)
    );

    // Sequencer: accept and present operands, capture ALU outputs, then retire with flag update and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_LOAD;
            r_rd         <= '0;
            r_imm        <= '0;
            r_y          <= '0;
            r_co         <= 1'b0;
            r_bo         <= 1'b0;
            r_z          <= 1'b0;
            r_p          <= 1'b0;
            r_inv        <= 1'b0;
            alu_opcode   <= '0;
            alu_carry_in <= 1'b0;
            flag_c       <= 1'b0;
            flag_z       <= 1'b0;
            flag_p       <= 1'b0;
            err_sticky   <= 1'b0;
            done_valid   <= 1'b0;
            done_err     <= 1'b0;
            done_result  <= '0;
        end else begin
            done_valid  <= 1'b0;
            done_err    <= 1'b0;
            done_result <= '0;
            case (r_state)
                S_IDLE: if (instr_valid) begin
                    r_op         <= instr_op;
                    r_rd         <= instr_rd;
                    r_imm        <= instr_imm;
                    alu_opcode   <= instr_op;
                    alu_carry_in <= flag_c;
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    r_y     <= alu_y;
                    r_co    <= alu_carry_out;
                    r_bo    <= alu_borrow;
                    r_z     <= alu_zero;
                    r_p     <= alu_parity;
                    r_inv   <= alu_invalid_op;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_state     <= S_IDLE;
                    done_valid  <= 1'b1;
                    done_err    <= !w_we;
                    done_result <= w_we ? w_wdata : '0;
                    err_sticky  <= err_sticky | !w_we;
                    if (w_we && !w_load) begin
                        flag_z <= r_z;
                        flag_p <= r_p;
                        flag_c <= uses_carry(r_op) ? r_co : uses_borrow(r_op) ? r_bo : flag_c;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: vector table, hand sequences and random traffic against a behavioural model
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = '0;
    logic [1:0] instr_rd = '0, instr_ra = '0, instr_rb = '0;
    logic [7:0] instr_imm = '0;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [3:0] alu_opcode;
    logic       alu_carry_in, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
    logic       done_valid, done_err;
    logic [7:0] done_result;
    logic       flag_c, flag_z, flag_p, err_sticky;
    logic [1:0] dbg_addr = '0;
    logic [7:0] dbg_data;
    logic [8:0] w_s;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] m_rf [4];
    logic       m_c, m_z, m_p, m_err;

    typedef struct {
        int op, rd, ra, rb, imm;
        int res, err, c, z, p, s;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.BUS_WIDTH(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_carry_in(alu_carry_in),
        .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_borrow(alu_borrow),
        .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
        .done_valid(done_valid), .done_result(done_result), .done_err(done_err),
        .flag_c(flag_c), .flag_z(flag_z), .flag_p(flag_p), .err_sticky(err_sticky),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stand-in for the attached combinational ALU
    always_comb begin
        w_s = '0;
        alu_borrow = 1'b0;
        alu_invalid_op = 1'b0;
        case (alu_opcode)
            OP_ADD:       w_s = {1'b0, alu_a} + {1'b0, alu_b};
            OP_ADD_CARRY: w_s = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
            OP_SUB:       begin w_s = {1'b0, alu_a - alu_b}; alu_borrow = alu_a < alu_b; end
            OP_INC:       w_s = {1'b0, alu_a} + 9'd1;
            OP_DEC:       begin w_s = {1'b0, alu_a - 8'd1}; alu_borrow = alu_a == 8'd0; end
            OP_AND:       w_s = {1'b0, alu_a & alu_b};
            OP_NOT:       w_s = {1'b0, ~alu_a};
            OP_ROL:       w_s = {1'b0, alu_a[6:0], alu_a[7]};
            OP_ROR:       w_s = {1'b0, alu_a[0], alu_a[7:1]};
            default:      alu_invalid_op = alu_opcode != OP_LOAD;
        endcase
    end
    assign alu_y         = w_s[7:0];
    assign alu_carry_out = w_s[8];
    assign alu_zero      = alu_y == 8'd0;
    assign alu_parity    = ^alu_y;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++) m_rf[r] = 8'd0;
        m_c = 1'b0; m_z = 1'b0; m_p = 1'b0; m_err = 1'b0;
    endtask

    // Architectural effect of one instruction, from the instruction-set rules in plain integer arithmetic
    task automatic model_step(input int op, input int rd, input int ra, input int rb, input int imm,
                              output int res, output int err);
        int a, b, y;
        a = int'(m_rf[ra]);
        b = int'(m_rf[rb]);
        y = 0;
        res = 0;
        err = 0;
        if (op >= 10) begin
            err = 1;
            m_err = 1'b1;
            return;
        end
        if (op == 0) begin
            res = imm;
            m_rf[rd] = 8'(imm);
            return;
        end
        case (op)
            1: y = a + b;
            2: y = a + b + int'(m_c);
            3: y = a - b;
            4: y = a + 1;
            5: y = a - 1;
            6: y = a & b;
            7: y = 255 - a;
            8: y = a * 2 + a / 128;
            default: y = a / 2 + (a % 2) * 128;
        endcase
        if (op == 1 || op == 2 || op == 4) m_c = y > 255;
        if (op == 3 || op == 5) m_c = y < 0;
        res = y & 255;
        m_z = res == 0;
        m_p = ($countones(res) % 2) == 1;
        m_rf[rd] = 8'(res);
    endtask

    task automatic chk_rf(input string name);
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            chk(name, {24'd0, dbg_data}, {24'd0, m_rf[r]});
        end
    endtask

    // One instruction through the handshake with fixed-latency and model checks; returns what the DUT reported
    task automatic issue(input int op, input int rd, input int ra, input int rb, input int imm,
                         output int res, output int err);
        int w, er, ee;
        logic [7:0] ea, eb;
        logic ec;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("idle_ready", {31'd0, instr_ready}, 32'd1);
        ea = m_rf[ra];
        eb = m_rf[rb];
        ec = m_c;
        instr_op = 4'(op); instr_rd = 2'(rd); instr_ra = 2'(ra); instr_rb = 2'(rb); instr_imm = 8'(imm);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("exec_ready", {31'd0, instr_ready}, 32'd0);
        chk("alu_a", {24'd0, alu_a}, {24'd0, ea});
        chk("alu_b", {24'd0, alu_b}, {24'd0, eb});
        chk("alu_opcode", {28'd0, alu_opcode}, 32'(op));
        chk("alu_carry_in", {31'd0, alu_carry_in}, {31'd0, ec});
        chk("done_early1", {31'd0, done_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_early2", {31'd0, done_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_valid", {31'd0, done_valid}, 32'd1);
        res = int'(done_result);
        err = int'(done_err);
        model_step(op, rd, ra, rb, imm, er, ee);
        chk("done_result", 32'(res), 32'(er));
        chk("done_err", 32'(err), 32'(ee));
        chk("flag_c", {31'd0, flag_c}, {31'd0, m_c});
        chk("flag_z", {31'd0, flag_z}, {31'd0, m_z});
        chk("flag_p", {31'd0, flag_p}, {31'd0, m_p});
        chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_err});
        @(posedge clk);
        #1;
        chk("done_pulse_width", {31'd0, done_valid}, 32'd0);
    endtask

    initial begin
        int res, err;
        tbl[0] = '{0, 1, 0, 0, 'hF0, 'hF0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 2, 0, 0, 'h20, 'h20, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 3, 1, 2, 0, 'h10, 0, 1, 0, 1, 0};
        tbl[3] = '{2, 0, 1, 2, 0, 'h11, 0, 1, 0, 0, 0};
        tbl[4] = '{3, 0, 2, 1, 0, 'h30, 0, 1, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 'h01, 'h01, 0, 1, 0, 0, 0};
        tbl[6] = '{5, 2, 1, 0, 0, 'h00, 0, 0, 1, 0, 0};
        tbl[7] = '{12, 3, 1, 2, 0, 'h00, 1, 0, 1, 0, 1};
        tbl[8] = '{1, 0, 3, 1, 0, 'h11, 0, 0, 0, 0, 1};
        tbl[9] = '{4, 1, 1, 0, 0, 'h02, 0, 0, 0, 1, 1};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("rst_flags", {29'd0, flag_c, flag_z, flag_p}, 32'd0);
        chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk_rf("rst_rf");

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].imm, res, err);
            chk("tbl_result", 32'(res), 32'(tbl[i].res));
            chk("tbl_err", 32'(err), 32'(tbl[i].err));
            chk("tbl_flags", {29'd0, flag_c, flag_z, flag_p}, 32'(tbl[i].c * 4 + tbl[i].z * 2 + tbl[i].p));
            chk("tbl_sticky", {31'd0, err_sticky}, 32'(tbl[i].s));
            chk_rf("tbl_rf");
        end
        dbg_addr = 2'd3;
        #1;
        chk("tbl_dbg_r3", {24'd0, dbg_data}, 32'h10);

        @(negedge clk);
        instr_op = OP_LOAD; instr_rd = 2'd0; instr_imm = 8'h5A;
        instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk("stream_ready", {31'd0, instr_ready}, 32'(c % 3 == 0));
            @(posedge clk);
            #1;
            chk("stream_done", {31'd0, done_valid}, 32'(c >= 2 && (c - 2) % 3 == 0));
            @(negedge clk);
        end
        instr_valid = 1'b0;
        m_rf[0] = 8'h5A;
        chk_rf("stream_rf");

        @(negedge clk);
        instr_op = OP_ADD; instr_rd = 2'd3; instr_ra = 2'd0; instr_rb = 2'd0;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_no_done", {31'd0, done_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_ready", {31'd0, instr_ready}, 32'd1);
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("rstmid_no_done", {31'd0, done_valid}, 32'd0);
            chk("rstmid_idle", {31'd0, instr_ready}, 32'd1);
        end
        chk("rstmid_flags", {28'd0, err_sticky, flag_c, flag_z, flag_p}, 32'd0);
        chk_rf("rstmid_rf");

        for (int i = 0; i < 200; i++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 0;
            issue(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), res, err);
            if (i % 10 == 9) chk_rf("rand_rf");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
